// File: rtl/mult_pkg.sv
// Shared types and sizing for the 8-bit signed shift-add multiplier.
// The state encoding is used by the sequencer FSM.
package mult_pkg;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mult_state_t;
  localparam int MULT_WIDTH = 8;
  localparam int MULT_ITERS = MULT_WIDTH;
endpackage

// File: rtl/add_sub9.sv
// Sign-extended ripple-carry adder/subtractor, WIDTH+1 bits; purely combinational.
// Subtract inverts the extended S operand and injects carry-in; carry-out is dropped.
import mult_pkg::*;

module add_sub9 #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] s,
  input  logic             sub,
  output logic [WIDTH:0]   res
);
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH+1:0] carry;

  assign a_ext = {a[WIDTH-1], a};
  assign b_ext = {s[WIDTH-1], s} ^ {(WIDTH+1){sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign res[i]     = a_ext[i] ^ b_ext[i] ^ carry[i];
    assign carry[i+1] = (a_ext[i] & b_ext[i]) | (carry[i] & (a_ext[i] ^ b_ext[i]));
  end

  logic unused_cout;
  assign unused_cout = carry[WIDTH+1];
endmodule

// File: rtl/shift_add_sequencer.sv
// Signed shift-add multiplier sequencer: product {X,A,B} in 2*WIDTH cycles after the start edge.
// No backpressure; Run is a level handshake and must drop in DONE before the next start.
import mult_pkg::*;

module shift_add_sequencer #(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Sw,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Xval,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t    state;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic           x_q;
  logic           busy_q, done_q;
  logic [WIDTH:0] sum;
  logic           is_last;

  assign is_last = (cnt == LAST);

  // The final iteration weighs the multiplier's sign bit negatively, hence subtract.
  add_sub9 #(.WIDTH(WIDTH)) u_add_sub (
    .a   (a_q),
    .s   (s_q),
    .sub (is_last),
    .res (sum)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      x_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            a_q <= '0;
            x_q <= 1'b0;
            b_q <= Sw;
          end else if (Run) begin
            a_q    <= '0;
            x_q    <= 1'b0;
            s_q    <= Sw;
            cnt    <= '0;
            state  <= ADD;
            busy_q <= 1'b1;
          end
        end
        ADD: begin
          if (b_q[0]) {x_q, a_q} <= sum;
          state <= SHIFT;
        end
        SHIFT: begin
          a_q <= {x_q, a_q[WIDTH-1:1]};
          b_q <= {a_q[0], b_q[WIDTH-1:1]};
          if (is_last) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
        DONE: begin
          if (!Run) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign Xval = x_q;
  assign Busy = busy_q;
  assign Done = done_q;
endmodule

// File: tb/tb_shift_add_sequencer.sv
// Directed-vector bench for shift_add_sequencer with hand-computed products.
`timescale 1ns/1ps
module tb_shift_add_sequencer;
  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] Sw;
  logic [7:0] Aval, Bval;
  logic       Xval, Busy, Done;

  int n_checks = 0;
  int n_pass   = 0;

  shift_add_sequencer dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .Sw           (Sw),
    .Aval         (Aval),
    .Bval         (Bval),
    .Xval         (Xval),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge Clk);
    #1;
  endtask

  task automatic load_b(input logic [7:0] v);
    ClearA_LoadB = 1'b1;
    Sw = v;
    step(1);
    ClearA_LoadB = 1'b0;
  endtask

  // Start edge plus 16 ADD/SHIFT cycles leaves the DUT in DONE.
  task automatic multiply(input logic [7:0] v);
    Run = 1'b1;
    Sw = v;
    step(1);
    step(16);
  endtask

  task automatic check_prod(input string tag, input logic [7:0] a, input logic [7:0] b, input logic x);
    chk({tag, "_done"}, Done, 1'b1);
    chk({tag, "_ab"}, {Aval, Bval}, {a, b});
    chk({tag, "_x"}, Xval, x);
  endtask

  task automatic release_run(input string tag);
    Run = 1'b0;
    step(1);
    chk({tag, "_busy_off"}, {Busy, Done}, 2'b00);
  endtask

  initial begin
    Reset_n = 1'b0;
    Run = 1'b1;
    ClearA_LoadB = 1'b0;
    Sw = 8'h55;
    step(2);
    chk("rst_regs", {Xval, Aval, Bval}, 17'h0);
    chk("rst_flags", {Busy, Done}, 2'b00);

    // Run held through reset: the first edge after release starts a multiply.
    Reset_n = 1'b1;
    step(1);
    chk("rst_start_busy", {Busy, Done}, 2'b10);
    step(16);
    check_prod("rst_mul", 8'h00, 8'h00, 1'b0);
    release_run("rst_mul");

    // -3 * 7 = -21
    load_b(8'hFD);
    chk("load_fd", Bval, 8'hFD);
    multiply(8'h07);
    check_prod("m7x_3", 8'hFF, 8'hEB, 1'b1);
    step(3);
    chk("done_held", {Busy, Done}, 2'b11);
    release_run("m7x_3");

    // -128 * -128 = 16384
    load_b(8'h80);
    multiply(8'h80);
    check_prod("m80x80", 8'h40, 8'h00, 1'b0);
    release_run("m80x80");

    // 5 * 3 = 15, then chained 2 * 15 = 30
    load_b(8'h03);
    multiply(8'h05);
    check_prod("m5x3", 8'h00, 8'h0F, 1'b0);
    release_run("m5x3");
    multiply(8'h02);
    check_prod("chain", 8'h00, 8'h1E, 1'b0);
    release_run("chain");

    // Load and Run together: load wins, start follows once the load drops.
    ClearA_LoadB = 1'b1;
    Run = 1'b1;
    Sw = 8'h03;
    step(1);
    chk("both_busy", Busy, 1'b0);
    chk("both_load", Bval, 8'h03);
    ClearA_LoadB = 1'b0;
    Sw = 8'h05;
    step(1);
    chk("both_start", Busy, 1'b1);
    step(16);
    check_prod("both_mul", 8'h00, 8'h0F, 1'b0);
    release_run("both_mul");

    // Inputs wiggled mid-operation must not disturb -3 * 7.
    load_b(8'hFD);
    Run = 1'b1;
    Sw = 8'h07;
    step(1);
    for (int i = 0; i < 10; i++) begin
      ClearA_LoadB = i[0];
      Sw = 8'(8'h31 * (i + 1));
      step(1);
    end
    ClearA_LoadB = 1'b0;
    step(6);
    check_prod("toggle", 8'hFF, 8'hEB, 1'b1);
    release_run("toggle");

    // Asynchronous reset mid-multiply.
    load_b(8'h03);
    Run = 1'b1;
    Sw = 8'h05;
    step(1);
    step(9);
    chk("mid_busy", Busy, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_regs", {Xval, Aval, Bval}, 17'h0);
    chk("arst_flags", {Busy, Done}, 2'b00);
    Run = 1'b0;
    step(1);
    Reset_n = 1'b1;
    step(2);
    chk("post_rst_idle", {Busy, Done, Bval}, 10'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
